// File: rtl/tmr_scrub_pkg.sv
// Shared types and helpers for the TMR scrub controller: FSM states, majority vote, popcount.
`ifndef TMR_SCRUB_PKG_SV
`define TMR_SCRUB_PKG_SV

// Bitwise majority of three equal-width vectors; a macro keeps it width-generic.
`define TMR_MAJ3(a, b, c) (((a) & (b)) | ((a) & (c)) | ((b) & (c)))

package tmr_scrub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int NUM_COPIES = 3;

    function automatic logic [1:0] popcount3(input logic [2:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
    endfunction

endpackage

`endif

// File: rtl/tmr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins but a coincident increment still lands.
module tmr_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Votes a triplicated register, flags disagreeing copies, and requests a write-back
// of the voted value through a valid/ready handshake while counting upsets per copy.
module tmr_scrub_ctrl
    import tmr_scrub_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic [WIDTH-1:0] voted,
    output logic             scrub_valid,
    input  logic             scrub_ready,
    output logic [WIDTH-1:0] scrub_data,
    output logic [2:0]       scrub_mask,
    output logic [CNT_W-1:0] err_cnt_a,
    output logic [CNT_W-1:0] err_cnt_b,
    output logic [CNT_W-1:0] err_cnt_c,
    output logic             multi_err,
    input  logic             cnt_clr
);

    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    state_t            state;
    state_t            next_state;
    logic [2:0]        mis;
    logic              detect;
    logic              handshake;
    logic [HOLD_W-1:0] hold_cnt;

    assign voted = `TMR_MAJ3(in_a, in_b, in_c);

    assign mis[0] = |(in_a ^ voted);
    assign mis[1] = |(in_b ^ voted);
    assign mis[2] = |(in_c ^ voted);

    assign detect      = (state == IDLE) && (|mis);
    assign handshake   = (state == REQ) && scrub_ready;
    assign scrub_valid = (state == REQ);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (|mis) next_state = REQ;
            REQ:  if (scrub_ready) next_state = HOLD;
            HOLD: if (hold_cnt == HOLD_W'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Leaving HOLD on the edge where the count reaches zero gives HOLD_CYC cycles of blanking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_cnt <= '0;
        end else if (handshake) begin
            hold_cnt <= HOLD_W'(HOLD_CYC);
        end else if (state == HOLD) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scrub_data <= '0;
            scrub_mask <= '0;
        end else if (detect) begin
            scrub_data <= voted;
            scrub_mask <= mis;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            multi_err <= 1'b0;
        end else if (cnt_clr) begin
            multi_err <= detect && (popcount3(mis) >= 2'd2);
        end else if (detect && (popcount3(mis) >= 2'd2)) begin
            multi_err <= 1'b1;
        end
    end

    tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk  (clk),
        .rstn (rstn),
        .inc  (detect && mis[0]),
        .clr  (cnt_clr),
        .cnt  (err_cnt_a)
    );

    tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk  (clk),
        .rstn (rstn),
        .inc  (detect && mis[1]),
        .clr  (cnt_clr),
        .cnt  (err_cnt_b)
    );

    tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt_c (
        .clk  (clk),
        .rstn (rstn),
        .inc  (detect && mis[2]),
        .clr  (cnt_clr),
        .cnt  (err_cnt_c)
    );

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed bench for tmr_scrub_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_tmr_scrub_ctrl;

    localparam int WIDTH    = 8;
    localparam int CNT_W    = 4;
    localparam int HOLD_CYC = 4;

    logic             clk;
    logic             rstn;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic [WIDTH-1:0] voted;
    logic             scrub_valid;
    logic             scrub_ready;
    logic [WIDTH-1:0] scrub_data;
    logic [2:0]       scrub_mask;
    logic [CNT_W-1:0] err_cnt_a;
    logic [CNT_W-1:0] err_cnt_b;
    logic [CNT_W-1:0] err_cnt_c;
    logic             multi_err;
    logic             cnt_clr;

    int checks = 0;
    int errors = 0;

    tmr_scrub_ctrl #(
        .WIDTH    (WIDTH),
        .CNT_W    (CNT_W),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_c        (in_c),
        .voted       (voted),
        .scrub_valid (scrub_valid),
        .scrub_ready (scrub_ready),
        .scrub_data  (scrub_data),
        .scrub_mask  (scrub_mask),
        .err_cnt_a   (err_cnt_a),
        .err_cnt_b   (err_cnt_b),
        .err_cnt_c   (err_cnt_c),
        .multi_err   (multi_err),
        .cnt_clr     (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        in_a = a;
        in_b = b;
        in_c = c;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_counts(input string tag, input int a, input int b, input int c);
        check_output({tag, "_cnt_a"}, 32'(err_cnt_a), 32'(a));
        check_output({tag, "_cnt_b"}, 32'(err_cnt_b), 32'(b));
        check_output({tag, "_cnt_c"}, 32'(err_cnt_c), 32'(c));
    endtask

    initial begin
        int exp_cnt;

        rstn        = 1'b0;
        scrub_ready = 1'b0;
        cnt_clr     = 1'b0;
        apply_stimulus(8'h5A, 8'h5A, 8'h5A);
        tick(2);
        check_output("rst_valid", 32'(scrub_valid), 32'd0);
        check_output("rst_data", 32'(scrub_data), 32'h00);
        check_output("rst_mask", 32'(scrub_mask), 32'd0);
        check_output("rst_multi", 32'(multi_err), 32'd0);
        check_output("rst_voted", 32'(voted), 32'h5A);
        check_counts("rst", 0, 0, 0);
        rstn = 1'b1;

        $display("[TB] all copies agree");
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_output("agree_voted", 32'(voted), 32'h5A);
            check_output("agree_valid", 32'(scrub_valid), 32'd0);
        end
        check_counts("agree", 0, 0, 0);

        $display("[TB] single upset on B, ready high");
        scrub_ready = 1'b1;
        apply_stimulus(8'h5A, 8'h5B, 8'h5A);
        #1;
        check_output("b_voted", 32'(voted), 32'h5A);
        tick(1);
        check_output("b_valid", 32'(scrub_valid), 32'd1);
        check_output("b_data", 32'(scrub_data), 32'h5A);
        check_output("b_mask", 32'(scrub_mask), 32'b010);
        check_counts("b", 0, 1, 0);
        tick(1);
        check_output("b_valid_drop", 32'(scrub_valid), 32'd0);
        apply_stimulus(8'h5A, 8'h5A, 8'h5A);
        tick(6);
        check_output("b_idle", 32'(scrub_valid), 32'd0);
        check_counts("b_after", 0, 1, 0);

        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check_counts("clr1", 0, 0, 0);

        $display("[TB] upset on B with ready held low");
        scrub_ready = 1'b0;
        apply_stimulus(8'h5A, 8'h5B, 8'h5A);
        tick(1);
        check_output("stall_valid0", 32'(scrub_valid), 32'd1);
        check_counts("stall0", 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) in_a = 8'h11;
            tick(1);
            check_output("stall_valid", 32'(scrub_valid), 32'd1);
            check_output("stall_data", 32'(scrub_data), 32'h5A);
            check_output("stall_mask", 32'(scrub_mask), 32'b010);
            check_output("stall_cnt_b", 32'(err_cnt_b), 32'd1);
        end
        apply_stimulus(8'h5A, 8'h5B, 8'h5A);
        scrub_ready = 1'b1;
        tick(1);
        check_output("stall_release", 32'(scrub_valid), 32'd0);
        apply_stimulus(8'h5A, 8'h5A, 8'h5A);
        tick(6);
        check_counts("stall_after", 0, 1, 0);

        $display("[TB] all three copies differ");
        apply_stimulus(8'h00, 8'hFF, 8'h0F);
        #1;
        check_output("multi_voted", 32'(voted), 32'h0F);
        tick(1);
        check_output("multi_valid", 32'(scrub_valid), 32'd1);
        check_output("multi_data", 32'(scrub_data), 32'h0F);
        check_output("multi_mask", 32'(scrub_mask), 32'b011);
        check_output("multi_flag", 32'(multi_err), 32'd1);
        check_counts("multi", 1, 2, 0);
        apply_stimulus(8'h5A, 8'h5A, 8'h5A);
        tick(1);
        check_output("multi_drop", 32'(scrub_valid), 32'd0);
        tick(6);
        check_output("multi_sticky", 32'(multi_err), 32'd1);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check_output("clr_multi", 32'(multi_err), 32'd0);
        check_counts("clr2", 0, 0, 0);

        $display("[TB] persistent upset on C, clear coincident with first detection");
        cnt_clr = 1'b1;
        apply_stimulus(8'h5A, 8'h5A, 8'h5B);
        tick(1);
        cnt_clr = 1'b0;
        check_output("coinc_valid", 32'(scrub_valid), 32'd1);
        check_output("coinc_mask", 32'(scrub_mask), 32'b100);
        check_output("coinc_multi", 32'(multi_err), 32'd0);
        check_counts("coinc", 0, 0, 1);
        for (int t = 1; t <= 300; t++) begin
            tick(1);
            exp_cnt = 1 + t / 6;
            if (exp_cnt > 15) exp_cnt = 15;
            check_output("sat_valid", 32'(scrub_valid), 32'((t % 6) == 0));
            check_output("sat_cnt_c", 32'(err_cnt_c), 32'(exp_cnt));
        end

        $display("[TB] reset during pending request");
        rstn = 1'b0;
        #1;
        check_output("arst_valid", 32'(scrub_valid), 32'd0);
        check_output("arst_mask", 32'(scrub_mask), 32'd0);
        check_output("arst_cnt_c", 32'(err_cnt_c), 32'd0);
        tick(1);
        rstn = 1'b1;
        tick(1);
        check_output("redetect_valid", 32'(scrub_valid), 32'd1);
        check_output("redetect_mask", 32'(scrub_mask), 32'b100);
        check_output("redetect_data", 32'(scrub_data), 32'h5A);
        check_output("redetect_cnt_c", 32'(err_cnt_c), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
